// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: a CPU read port and a loader read/write port share one
// synchronous memory through a four-state IDLE/ISSUE/CAPTURE/ACK sequence with round-robin ties.
module mem_port_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        grant,
    output logic [7:0]        cpu_wait_cnt,
    input  logic              clr_stat
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_e;

    state_e            state_q;
    logic              owner_ldr_q;
    logic              last_ldr_q;
    logic              we_q;
    logic              cpu_ack_q;
    logic              ldr_ack_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;
    logic [1:0]        grant_q;
    logic [7:0]        wait_cnt_q;
    logic [7:0]        wait_cnt_d;

    logic cpu_win;
    logic ldr_win;
    logic cpu_served;

    // On a tie the port that did not win last time goes first.
    assign cpu_win = cpu_req && (!ldr_req || last_ldr_q);
    assign ldr_win = ldr_req && !cpu_win;

    // The IDLE cycle in which the CPU wins arbitration is not a stall.
    assign cpu_served = (state_q == IDLE) ? cpu_win : !owner_ldr_q;

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr_stat) begin
            wait_cnt_d = 8'd0;
        end else if (cpu_req && !cpu_served && (wait_cnt_q != 8'hFF)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    // NOTE: sequential state is written with <= only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_ldr_q <= 1'b0;
            last_ldr_q  <= 1'b1;
            we_q        <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
            grant_q     <= 2'b00;
            wait_cnt_q  <= 8'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            cpu_ack_q  <= 1'b0;
            ldr_ack_q  <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_win || ldr_win) begin
                        state_q     <= ISSUE;
                        owner_ldr_q <= ldr_win;
                        last_ldr_q  <= ldr_win;
                        we_q        <= ldr_win && ldr_we;
                        grant_q     <= ldr_win ? 2'b10 : 2'b01;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= ldr_win && ldr_we;
                        mem_addr_q  <= ldr_win ? ldr_addr : cpu_addr;
                        // The CPU never writes, so its grant leaves the write bus as it was.
                        if (ldr_win) begin
                            mem_wdata_q <= ldr_wdata;
                        end
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    state_q <= ACK;
                    if (!we_q) begin
                        if (owner_ldr_q) begin
                            ldr_rdata_q <= mem_rdata;
                        end else begin
                            cpu_rdata_q <= mem_rdata;
                        end
                    end
                    if (owner_ldr_q) begin
                        ldr_ack_q <= 1'b1;
                    end else begin
                        cpu_ack_q <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= 2'b00;
                end
            endcase
        end
    end

    assign cpu_ack      = cpu_ack_q;
    assign ldr_ack      = ldr_ack_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign ldr_rdata    = ldr_rdata_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign grant        = grant_q;
    assign cpu_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: emulated memory, a transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_req = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic       cpu_ack;
    logic [7:0] cpu_rdata;
    logic       ldr_req = 1'b0;
    logic       ldr_we = 1'b0;
    logic [7:0] ldr_addr = '0;
    logic [7:0] ldr_wdata = '0;
    logic       ldr_ack;
    logic [7:0] ldr_rdata;
    logic       mem_en;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [1:0] grant;
    logic [7:0] cpu_wait_cnt;
    logic       clr_stat = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .grant(grant), .cpu_wait_cnt(cpu_wait_cnt), .clr_stat(clr_stat)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        if (i == 8'h10) return 8'hA5;
        if (i == 8'h55) return 8'h11;
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Memory emulation: registered read, data valid the cycle after mem_en.
    logic [7:0] ram [256];
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (mem_en === 1'b1) begin
                if (mem_we === 1'b1) ram[mem_addr] = mem_wdata;
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Reference model: a transaction occupies four cycles (phase 0 = idle, 1..3 busy).
    logic [7:0] gold [256];
    int         m_phase;
    bit         m_owner;     // 0 CPU, 1 loader
    bit         m_last_ldr;
    bit         m_we;
    logic [7:0] m_addr, m_wdata, m_cpu_rdata, m_ldr_rdata;
    int         m_wait;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last_ldr = 1; m_we = 0;
        m_addr = 0; m_wdata = 0; m_cpu_rdata = 0; m_ldr_rdata = 0; m_wait = 0;
    endtask

    task automatic model_step();
        bit cpu_wins, cpu_served;
        cpu_wins   = cpu_req && (!ldr_req || m_last_ldr);
        cpu_served = (m_phase == 0) ? cpu_wins : (m_owner == 0);
        if (clr_stat) m_wait = 0;
        else if (cpu_req && !cpu_served && m_wait < 255) m_wait = m_wait + 1;
        if (m_phase == 0) begin
            if (cpu_req || ldr_req) begin
                m_owner    = !cpu_wins;
                m_last_ldr = m_owner;
                m_we       = m_owner && ldr_we;
                m_addr     = m_owner ? ldr_addr : cpu_addr;
                if (m_owner) m_wdata = ldr_wdata;
                m_phase = 1;
            end
        end else begin
            if (m_phase == 1 && m_we) gold[m_addr] = m_wdata;
            if (m_phase == 2 && !m_we) begin
                if (m_owner) m_ldr_rdata = gold[m_addr];
                else         m_cpu_rdata = gold[m_addr];
            end
            m_phase = (m_phase + 1) % 4;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) gold[i] = init_val(i);
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("grant", grant, (m_phase == 0) ? 2'b00 : (m_owner ? 2'b10 : 2'b01));
                check("mem_en", mem_en, m_phase == 1);
                check("mem_we", mem_we, (m_phase == 1) && m_we);
                check("mem_addr", mem_addr, m_addr);
                check("mem_wdata", mem_wdata, m_wdata);
                check("cpu_ack", cpu_ack, (m_phase == 3) && !m_owner);
                check("ldr_ack", ldr_ack, (m_phase == 3) && m_owner);
                check("cpu_rdata", cpu_rdata, m_cpu_rdata);
                check("ldr_rdata", ldr_rdata, m_ldr_rdata);
                check("cpu_wait_cnt", cpu_wait_cnt, m_wait);
            end
        end
    end

    task automatic pulse_clr();
        @(negedge clk);
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        check("clr_to_zero", cpu_wait_cnt, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int ack_q[$];
        int idx_q[$];
        int n, seen_grant;
        bit got;

        // Reset values
        repeat (2) @(negedge clk);
        #2;
        check("rst_grant", grant, 2'b00);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_acks", {cpu_ack, ldr_ack}, 2'b00);
        check("rst_rdata", {cpu_rdata, ldr_rdata}, 16'h0000);
        check("rst_bus", {mem_addr, mem_wdata}, 16'h0000);
        check("rst_wait", cpu_wait_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // CPU-only read of 0x10
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 8'h10;
        @(negedge clk);
        check("t1_mem_en", mem_en, 1);
        check("t1_addr", mem_addr, 8'h10);
        check("t1_grant", grant, 2'b01);
        @(negedge clk);
        check("t1_no_early_ack", cpu_ack, 0);
        @(negedge clk);
        check("t1_ack", cpu_ack, 1);
        check("t1_rdata", cpu_rdata, 8'hA5);
        cpu_req = 1'b0;

        // Loader write 0x3C to 0x20, then CPU read back
        @(negedge clk);
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h20; ldr_wdata = 8'h3C;
        @(negedge clk);
        check("t2_we_issue", {mem_en, mem_we}, 2'b11);
        check("t2_bus", {mem_addr, mem_wdata}, 16'h203C);
        check("t2_grant", grant, 2'b10);
        @(negedge clk);
        check("t2_we_capture", mem_we, 0);
        @(negedge clk);
        check("t2_ldr_ack", ldr_ack, 1);
        check("t2_ldr_rdata_kept", ldr_rdata, 8'h00);
        ldr_req = 1'b0; ldr_we = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 8'h20;
        @(negedge clk);
        check("t2_cpu_no_we", {mem_en, mem_we}, 2'b10);
        repeat (2) @(negedge clk);
        check("t2_cpu_ack", cpu_ack, 1);
        check("t2_readback", cpu_rdata, 8'h3C);
        cpu_req = 1'b0;

        // Both requesters held from reset: CPU first, then alternate every 4 cycles
        do_reset();
        @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 8'h05;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 8'h06;
        n = 0;
        while (ack_q.size() < 4 && n < 24) begin
            @(negedge clk);
            n++;
            if (cpu_ack) begin ack_q.push_back(1); idx_q.push_back(n); end
            if (ldr_ack) begin ack_q.push_back(2); idx_q.push_back(n); end
        end
        check("t3_ack_count", ack_q.size(), 4);
        if (ack_q.size() >= 4) begin
            check("t3_order0", ack_q[0], 1);
            check("t3_order1", ack_q[1], 2);
            check("t3_order2", ack_q[2], 1);
            check("t3_order3", ack_q[3], 2);
            check("t3_first_latency", idx_q[0], 3);
            for (int i = 1; i < 4; i++) check("t3_spacing", idx_q[i] - idx_q[i-1], 4);
        end

        // CPU stays high until its pending ack, then only the loader keeps requesting
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack) got = 1;
        end
        check("t4_pending_cpu_ack", got, 1);
        cpu_req = 1'b0;
        repeat (9) @(negedge clk);
        pulse_clr();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        cpu_req = 1'b1; cpu_addr = 8'h10;
        n = 0; seen_grant = -1; got = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (grant == 2'b01 && seen_grant < 0) seen_grant = n;
            if (cpu_ack) begin
                got = 1;
                check("t4_wait_le3", cpu_wait_cnt <= 8'd3, 1);
                check("t4_rdata", cpu_rdata, 8'hA5);
            end
        end
        check("t4_acked", got, 1);
        check("t4_grant_within4", (seen_grant >= 1) && (seen_grant <= 4), 1);
        cpu_req = 1'b0;

        // Long contention: cumulative stall count saturates, clear wins
        pulse_clr();
        cpu_req = 1'b1; cpu_addr = 8'h07;
        repeat (800) @(negedge clk);
        check("t5_saturated", cpu_wait_cnt, 8'd255);
        clr_stat = 1'b1;
        @(negedge clk);
        clr_stat = 1'b0;
        check("t5_cleared", cpu_wait_cnt, 8'd0);
        cpu_req = 1'b0; ldr_req = 1'b0;
        repeat (8) @(negedge clk);

        // Reset during the ISSUE cycle of a loader write
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h55; ldr_wdata = 8'h99;
        got = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if (mem_we) got = 1;
        end
        check("t6_reached_issue", got, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_async_drop", {mem_en, mem_we}, 2'b00);
        check("t6_grant", grant, 2'b00);
        check("t6_no_ack", ldr_ack, 0);
        ldr_req = 1'b0; ldr_we = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("t6_no_ack_in_reset", ldr_ack, 0);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_mem_untouched", ram[8'h55], 8'h11);

        // Random traffic, including drops before grant and input changes while owned
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            if (cpu_req) begin
                if (cpu_ack) begin
                    if ($urandom_range(0, 1) == 0) cpu_req = 1'b0;
                    else cpu_addr = 8'($urandom_range(0, 15));
                end else if (grant == 2'b01) begin
                    cpu_addr = 8'($urandom_range(0, 255));
                end else if ($urandom_range(0, 9) == 0) begin
                    cpu_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                cpu_req = 1'b1;
                cpu_addr = 8'($urandom_range(0, 15));
            end
            if (ldr_req) begin
                if (ldr_ack) begin
                    if ($urandom_range(0, 1) == 0) ldr_req = 1'b0;
                    ldr_we = 1'($urandom_range(0, 1));
                    ldr_addr = 8'($urandom_range(0, 15));
                    ldr_wdata = 8'($urandom);
                end else if (grant == 2'b10) begin
                    ldr_we = 1'($urandom_range(0, 1));
                    ldr_addr = 8'($urandom_range(0, 255));
                    ldr_wdata = 8'($urandom);
                end else if ($urandom_range(0, 9) == 0) begin
                    ldr_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                ldr_req = 1'b1;
                ldr_we = 1'($urandom_range(0, 1));
                ldr_addr = 8'($urandom_range(0, 15));
                ldr_wdata = 8'($urandom);
            end
            clr_stat = ($urandom_range(0, 24) == 0);
        end
        cpu_req = 1'b0; ldr_req = 1'b0; clr_stat = 1'b0;
        repeat (6) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL expose parameter ADDR_W, default 8, memory address width.
REQ-002 The block SHALL expose parameter DATA_W, default 8, memory data width.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU read request, level; held until cpu_ack.
- cpu_addr  in  ADDR_W  CPU read address.
- cpu_ack  out  1  one-cycle pulse, cpu_rdata valid.
- cpu_rdata  out  DATA_W  registered CPU read data.
- ldr_req  in  1  loader request, level; held until ldr_ack.
- ldr_we  in  1  loader write (1) / read (0).
- ldr_addr  in  ADDR_W  loader address.
- ldr_wdata  in  DATA_W  loader write data.
- ldr_ack  out  1  one-cycle pulse, loader access complete.
- ldr_rdata  out  DATA_W  registered loader read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en.
- grant  out  2  current owner: 01 CPU, 10 loader, 00 none.
- cpu_wait_cnt  out  8  saturating count of CPU stall cycles.
- clr_stat  in  1  synchronous clear of cpu_wait_cnt.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, CAPTURE, ACK; transitions IDLE->ISSUE (any req), ISSUE->CAPTURE, CAPTURE->ACK, ACK->IDLE unconditionally.
REQ-005 In IDLE with exactly one req high, that requester SHALL be granted.
REQ-006 In IDLE with both req high, grant SHALL go to the requester not granted last (round-robin); after reset the CPU SHALL win the first tie.
REQ-007 On grant the owner's address, we and wdata SHALL be latched; later requester input changes SHALL NOT affect the transaction.
REQ-008 CPU transactions SHALL always be reads (mem_we=0).
REQ-009 mem_en SHALL be 1 only in ISSUE; mem_we SHALL be 1 only in ISSUE and only for a latched loader write.
REQ-010 mem_addr/mem_wdata SHALL drive latched values in ISSUE and hold them otherwise.
REQ-011 In CAPTURE, for a read, mem_rdata SHALL be registered into the owner's rdata register; the other port's rdata SHALL be unchanged.
REQ-012 For a loader write, ldr_rdata SHALL be unchanged.
REQ-013 The owner's ack SHALL be 1 for exactly the ACK cycle; latency from IDLE-cycle request sample to ack SHALL be 3 cycles.
REQ-014 grant SHALL be non-zero from ISSUE through ACK and 00 in IDLE.
REQ-015 A req still high in the IDLE cycle after ack SHALL be treated as a new request (back-to-back allowed; the 4-cycle period gives 25% bus occupancy per port max).
REQ-016 A req dropped before its ack SHALL be ignored if not yet granted; a granted transaction SHALL complete regardless.
REQ-017 cpu_wait_cnt SHALL increment each cycle cpu_req=1 and the CPU is neither owner nor in ACK, saturate at 255, and clear when clr_stat=1 (clear wins over increment).

Reset
REQ-018 On reset_n low, the block SHALL immediately enter IDLE and drive cpu_ack, ldr_ack, mem_en, mem_we = 0, grant = 00, cpu_rdata = ldr_rdata = mem_addr = mem_wdata = 0, cpu_wait_cnt = 0, round-robin pointer = loader-last.
REQ-019 A reset asserted mid-transaction SHALL abort it with no ack issued; mem_we SHALL drop asynchronously.

Verification
REQ-020 The bench SHALL cover:
- CPU-only read, memory[0x10]=0xA5: cpu_req at cycle 0 -> mem_en cycle 1 addr 0x10, cpu_ack cycle 3, cpu_rdata=0xA5.
- Loader write 0x3C to 0x20, then CPU read 0x20 -> mem_we only in loader ISSUE; cpu_rdata=0x3C.
- Both req high from reset, held -> grants alternate CPU, loader, CPU, loader; acks every 4 cycles.
- Loader holds req continuously while CPU requests once -> CPU granted within 4 cycles; cpu_wait_cnt ≤3 for that request.
- CPU starved 300 cycles (e.g., held in reset-free stall via forced loader ownership model) -> cpu_wait_cnt = 255, clr_stat -> 0 next cycle.
- reset_n low during ISSUE of loader write -> mem_en/mem_we 0 immediately, no ldr_ack, grant=00.
